// File: rtl/pcie_us_axis_cc_arb_mux_pkg.sv
// Shared constants and helpers for the UltraScale PCIe CC stream arbiter/mux.
// Data-width legality and the tuser width that goes with each data width.
package pcie_us_axis_cc_arb_mux_pkg;

    localparam int DWORD_WIDTH = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    function automatic bit legal_data_width(input int data_width);
        return (data_width == 64) || (data_width == 128) ||
               (data_width == 256) || (data_width == 512);
    endfunction

    function automatic int cc_user_width(input int data_width);
        return (data_width < 512) ? 33 : 81;
    endfunction

endpackage

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
// Zero latency, no state; the caller owns and advances the pointer.
module pcie_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_index,
    output logic             grant_found
);

    logic [N-1:0]     req_hi;
    logic [IDX_W-1:0] hi_index;
    logic [IDX_W-1:0] lo_index;
    logic             hi_any;

    always_comb begin
        req_hi   = '0;
        hi_index = '0;
        lo_index = '0;
        hi_any   = 1'b0;
        for (int j = 0; j < N; j++) begin
            req_hi[j] = req[j] && (j >= int'(ptr));
        end
        // Scan downwards so the last hit is the lowest index.
        for (int j = N - 1; j >= 0; j--) begin
            if (req_hi[j]) begin
                hi_index = IDX_W'(j);
                hi_any   = 1'b1;
            end
            if (req[j]) begin
                lo_index = IDX_W'(j);
            end
        end
    end

    always_comb begin
        grant_found = |req;
        grant_index = hi_any ? hi_index : lo_index;
        grant       = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = grant_found && (grant_index == IDX_W'(j));
        end
    end

endmodule

// File: rtl/pcie_us_axis_cc_arb_mux.sv
// Round-robin, frame-locked merge of S_COUNT CC streams onto the PCIe core CC port.
// Input to output two cycles from idle, one beat/cycle after; registered skid output, no comb tready path.
module pcie_us_axis_cc_arb_mux
    import pcie_us_axis_cc_arb_mux_pkg::*;
#(
    parameter int S_COUNT                 = 2,
    parameter int AXIS_PCIE_DATA_WIDTH    = 512,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int AXIS_PCIE_CC_USER_WIDTH = cc_user_width(AXIS_PCIE_DATA_WIDTH),
    localparam int IDX_W                  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,

    input  logic [S_COUNT*AXIS_PCIE_DATA_WIDTH-1:0]      s_axis_cc_tdata,
    input  logic [S_COUNT*AXIS_PCIE_KEEP_WIDTH-1:0]      s_axis_cc_tkeep,
    input  logic [S_COUNT-1:0]                           s_axis_cc_tvalid,
    output logic [S_COUNT-1:0]                           s_axis_cc_tready,
    input  logic [S_COUNT-1:0]                           s_axis_cc_tlast,
    input  logic [S_COUNT*AXIS_PCIE_CC_USER_WIDTH-1:0]   s_axis_cc_tuser,

    output logic [AXIS_PCIE_DATA_WIDTH-1:0]              m_axis_cc_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]              m_axis_cc_tkeep,
    output logic                                         m_axis_cc_tvalid,
    input  logic                                         m_axis_cc_tready,
    output logic                                         m_axis_cc_tlast,
    output logic [AXIS_PCIE_CC_USER_WIDTH-1:0]           m_axis_cc_tuser,

    output logic                                         grant_valid,
    output logic [IDX_W-1:0]                             grant_index
);

    if (!legal_data_width(AXIS_PCIE_DATA_WIDTH)) begin : g_err_data_width
        $error("pcie_us_axis_cc_arb_mux: AXIS_PCIE_DATA_WIDTH must be 64, 128, 256 or 512");
    end
    if (AXIS_PCIE_KEEP_WIDTH * DWORD_WIDTH != AXIS_PCIE_DATA_WIDTH) begin : g_err_keep_width
        $error("pcie_us_axis_cc_arb_mux: AXIS_PCIE_KEEP_WIDTH must be AXIS_PCIE_DATA_WIDTH/32");
    end
    if (AXIS_PCIE_CC_USER_WIDTH != cc_user_width(AXIS_PCIE_DATA_WIDTH)) begin : g_err_user_width
        $error("pcie_us_axis_cc_arb_mux: AXIS_PCIE_CC_USER_WIDTH does not match data width");
    end
    if (S_COUNT < 1 || S_COUNT > 16) begin : g_err_s_count
        $error("pcie_us_axis_cc_arb_mux: S_COUNT must be 1..16");
    end

    typedef struct packed {
        logic [AXIS_PCIE_DATA_WIDTH-1:0]    tdata;
        logic [AXIS_PCIE_KEEP_WIDTH-1:0]    tkeep;
        logic                               tlast;
        logic [AXIS_PCIE_CC_USER_WIDTH-1:0] tuser;
    } cc_beat_t;

    arb_state_t       state;
    logic [S_COUNT-1:0] grant_oh;
    logic [IDX_W-1:0] rr_ptr;

    logic [S_COUNT-1:0] arb_grant;
    logic [IDX_W-1:0] arb_index;
    logic             arb_found;

    cc_beat_t         sel_beat;
    cc_beat_t         out_beat;
    cc_beat_t         temp_beat;
    logic             out_valid;
    logic             temp_valid;
    logic             ready_int;
    logic             accept;

    pcie_rr_arbiter #(
        .N     (S_COUNT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (s_axis_cc_tvalid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .grant_found (arb_found)
    );

    // Readiness comes only from flops, so the core's tready never reaches the sources combinationally.
    always_comb begin
        s_axis_cc_tready = '0;
        if (state == ST_ACTIVE) begin
            s_axis_cc_tready = grant_oh & {S_COUNT{ready_int}};
        end
    end

    assign accept = |(s_axis_cc_tvalid & s_axis_cc_tready);

    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_oh[i]) begin
                sel_beat.tdata = s_axis_cc_tdata[i*AXIS_PCIE_DATA_WIDTH +: AXIS_PCIE_DATA_WIDTH];
                sel_beat.tkeep = s_axis_cc_tkeep[i*AXIS_PCIE_KEEP_WIDTH +: AXIS_PCIE_KEEP_WIDTH];
                sel_beat.tlast = s_axis_cc_tlast[i];
                sel_beat.tuser = s_axis_cc_tuser[i*AXIS_PCIE_CC_USER_WIDTH +: AXIS_PCIE_CC_USER_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            grant_oh    <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_index <= arb_index;
                        grant_oh    <= arb_grant;
                        grant_valid <= 1'b1;
                        state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // The grant is held across source gaps until the frame's last beat is taken.
                    if (accept && sel_beat.tlast) begin
                        rr_ptr      <= (grant_index == IDX_W'(S_COUNT - 1)) ? '0 : grant_index + 1'b1;
                        grant_oh    <= '0;
                        grant_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                    grant_oh    <= '0;
                end
            endcase
        end
    end

    // Skid control: a full temp register always implies ready_int was dropped the cycle it filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            temp_valid <= 1'b0;
            ready_int  <= 1'b0;
        end else begin
            ready_int <= m_axis_cc_tready || (!out_valid && !temp_valid);
            if (m_axis_cc_tready || !out_valid) begin
                if (temp_valid) begin
                    out_valid  <= 1'b1;
                    temp_valid <= 1'b0;
                end else begin
                    out_valid  <= accept;
                end
            end else if (accept) begin
                temp_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (m_axis_cc_tready || !out_valid) begin
            if (temp_valid) begin
                out_beat <= temp_beat;
            end else if (accept) begin
                out_beat <= sel_beat;
            end
        end else if (accept) begin
            temp_beat <= sel_beat;
        end
    end

    assign m_axis_cc_tdata  = out_beat.tdata;
    assign m_axis_cc_tkeep  = out_beat.tkeep;
    assign m_axis_cc_tlast  = out_beat.tlast;
    assign m_axis_cc_tuser  = out_beat.tuser;
    assign m_axis_cc_tvalid = out_valid;

endmodule
